mem_pipe_ctrl: RTL and testbench



---
 rtl/mem_pipe_ctrl_pkg.sv | 22 ++
 rtl/mem_pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_pipe_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pipe_ctrl_pkg.sv
// Shared types for the memory arbiter / pipeline sequencer.
// Controller state, RAM grant select and RAM handshake state.
package mem_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1
    } ctrl_state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } mem_grant_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_pipe_ctrl.sv
// Single-port RAM arbiter and 5-stage pipeline sequencer.
// Data access wins the port; the pipeline only advances on a completed fetch.
module mem_pipe_ctrl
    import mem_pipe_ctrl_pkg::*;
#(
    parameter int ERR_LIMIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    input  logic        brTaken,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ihit,
    output logic        ifidW,
    output logic        idexW,
    output logic        exmemW,
    output logic        memwbW,
    output logic        ifidRST,
    output logic        idexRST,
    output logic        exmemRST,
    output logic        halted,
    output logic        mem_err
);

    localparam int CW = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ERR_LIMIT - 1);

    ctrl_state_t   state_q, state_d;
    mem_grant_t    grant;
    logic          d_done_q, d_done_d;
    logic [31:0]   dload_q, dload_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          mem_err_q, mem_err_d;

    logic          run, dreq, hit, err_st, fetch;
    logic          dhit, ihit_c, advance, err_fatal;
    logic          ren_c, wen_c;
    logic [31:0]   addr_c, store_c;

    // Grant mux, hit decode, halt/error transitions and latch next-state
    always_comb begin
        run       = (state_q == RUN);
        dreq      = (dREN | dWEN) & ~d_done_q;
        hit       = (ramstate == ACCESS);
        err_st    = (ramstate == ERROR);
        grant     = (run & dreq) ? GNT_DATA : GNT_INSTR;
        fetch     = run & ~dreq & ~halt;
        ren_c     = 1'b0;
        wen_c     = 1'b0;
        addr_c    = '0;
        store_c   = '0;
        if (grant == GNT_DATA) begin
            addr_c  = daddr;
            ren_c   = dREN & ~dWEN;
            wen_c   = dWEN;
            store_c = dstore;
        end else if (fetch) begin
            addr_c  = iaddr;
            ren_c   = 1'b1;
        end
        dhit      = (grant == GNT_DATA) & hit;
        ihit_c    = fetch & hit;
        advance   = ihit_c;
        err_fatal = run & err_st & (err_cnt_q == CNT_LAST);

        state_d = state_q;
        if (run & (err_fatal | (halt & ~dreq)))
            state_d = HALT;

        d_done_d = d_done_q;
        if (advance)
            d_done_d = 1'b0;
        else if (dhit)
            d_done_d = 1'b1;

        dload_d = dhit ? ramload : dload_q;

        err_cnt_d = err_cnt_q;
        if (hit)
            err_cnt_d = '0;
        else if (run & err_st & ~err_fatal)
            err_cnt_d = err_cnt_q + 1'b1;

        mem_err_d = mem_err_q | err_fatal;
    end

    // Controller state, data-done latch, load data hold and error counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RUN;
            d_done_q  <= 1'b0;
            dload_q   <= '0;
            err_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_done_q  <= d_done_d;
            dload_q   <= dload_d;
            err_cnt_q <= err_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Reset forces every control output low without waiting for a clock
    assign ramREN   = ren_c & ~RST;
    assign ramWEN   = wen_c & ~RST;
    assign ramaddr  = RST ? '0 : addr_c;
    assign ramstore = RST ? '0 : store_c;
    assign iload    = ramload;
    assign dload    = RST ? '0 : (dhit ? ramload : dload_q);
    assign ihit     = ihit_c & ~RST;
    assign ifidW    = advance & ~RST;
    assign idexW    = advance & ~RST;
    assign exmemW   = advance & ~RST;
    assign memwbW   = advance & ~RST;
    assign ifidRST  = advance & brTaken & ~RST;
    assign idexRST  = advance & brTaken & ~RST;
    assign exmemRST = advance & brTaken & ~RST;
    assign halted   = (state_q == HALT) & ~RST;
    assign mem_err  = mem_err_q & ~RST;

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// Bench for mem_pipe_ctrl: directed vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_pipe_ctrl;

    localparam int LIM = 15;
    localparam logic [1:0] S_FREE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        dREN, dWEN, halt, brTaken;
    logic [1:0]  ramstate;
    logic        ramREN, ramWEN, ihit, halted, mem_err;
    logic [31:0] ramaddr, ramstore, iload, dload;
    logic        ifidW, idexW, exmemW, memwbW;
    logic        ifidRST, idexRST, exmemRST;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem_pipe_ctrl #(.ERR_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt), .brTaken(brTaken),
        .ramstate(ramstate), .ramload(ramload), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .iload(iload), .dload(dload), .ihit(ihit), .ifidW(ifidW),
        .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
        .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST),
        .halted(halted), .mem_err(mem_err)
    );

    typedef struct packed {
        logic        ren, wen, ihit;
        logic [3:0]  w;
        logic [2:0]  fl;
        logic        hlt, merr;
        logic [31:0] addr, store, dl;
    } out_t;

    // Model state: has the MEM-stage access finished, is the core halted,
    // how many ERROR cycles in a row, last captured load data.
    bit          m_done, m_halted, m_err;
    int          m_run;
    logic [31:0] m_dload;

    function automatic out_t model_exp();
        out_t e = '0;
        bit   want;
        if (RST) return e;
        e.hlt  = m_halted;
        e.merr = m_err;
        e.dl   = m_dload;
        if (m_halted) return e;
        want = (dREN | dWEN) && !m_done;
        if (want) begin
            e.addr  = daddr;
            e.store = dstore;
            e.wen   = dWEN;
            e.ren   = dREN && !dWEN;
            if (ramstate == S_ACC) e.dl = ramload;
        end else if (!halt) begin
            e.addr = iaddr;
            e.ren  = 1'b1;
            if (ramstate == S_ACC) begin
                e.ihit = 1'b1;
                e.w    = 4'hF;
                e.fl   = brTaken ? 3'b111 : 3'b000;
            end
        end
        return e;
    endfunction

    task automatic model_update();
        bit want;
        if (RST) begin
            m_done = 0; m_halted = 0; m_err = 0; m_run = 0; m_dload = '0;
            return;
        end
        if (m_halted) return;
        want = (dREN | dWEN) && !m_done;
        if (ramstate == S_ERR) begin
            m_run++;
            if (m_run == LIM) begin
                m_err = 1; m_halted = 1;
            end
        end else if (ramstate == S_ACC) begin
            m_run = 0;
        end
        if (want && ramstate == S_ACC) begin
            m_done = 1; m_dload = ramload;
        end else if (!want && !halt && ramstate == S_ACC) begin
            m_done = 0;
        end
        if (!want && halt) m_halted = 1;
    endtask

    function automatic out_t dut_out();
        out_t a;
        a.ren   = ramREN;
        a.wen   = ramWEN;
        a.ihit  = ihit;
        a.w     = {ifidW, idexW, exmemW, memwbW};
        a.fl    = {ifidRST, idexRST, exmemRST};
        a.hlt   = halted;
        a.merr  = mem_err;
        a.addr  = ramaddr;
        a.store = ramstore;
        a.dl    = dload;
        return a;
    endfunction

    // Compare against the model at the negedge, then advance the model.
    task automatic cyc_check(input string nm);
        out_t e, a;
        @(negedge CLK);
        e = model_exp();
        a = dut_out();
        if (!(e.ren | e.wen)) begin
            a.addr = '0; e.addr = '0; a.store = '0; e.store = '0;
        end
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, a, e);
        end
        model_update();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        dREN = 0; dWEN = 0; halt = 0; brTaken = 0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = S_ACC;
    endtask

    task automatic do_reset();
        RST = 1;
        cyc_check("reset");
        tick();
        RST = 0;
    endtask

    typedef struct {
        logic        ren_, wen_, hlt_, br;
        logic [1:0]  st;
        logic [31:0] ia, da, ds, rl;
        logic        e_ren, e_wen, e_ihit, e_w, e_fl;
        logic [31:0] e_addr, e_dl;
    } vec_t;

    vec_t tab[15];

    initial begin
        // dREN dWEN halt br  st     iaddr  daddr  dstore  ramload
        //  -> ren wen ihit W flush addr dload
        tab[0]  = '{0,0,0,0,S_ACC, 32'h0, 0,0,0, 1,0,1,1,0, 32'h0, 0};
        tab[1]  = '{0,0,0,0,S_ACC, 32'h4, 0,0,0, 1,0,1,1,0, 32'h4, 0};
        tab[2]  = '{1,0,0,0,S_ACC, 32'h8, 32'h100,0,32'hDEADBEEF,
                    1,0,0,0,0, 32'h100, 32'hDEADBEEF};
        tab[3]  = '{1,0,0,0,S_ACC, 32'h8, 32'h100,0,0,
                    1,0,1,1,0, 32'h8, 32'hDEADBEEF};
        tab[4]  = '{0,1,0,0,S_BUSY,32'hC, 32'h200,32'h12345678,0,
                    0,1,0,0,0, 32'h200, 32'hDEADBEEF};
        tab[5]  = '{0,1,0,0,S_BUSY,32'hC, 32'h200,32'h12345678,0,
                    0,1,0,0,0, 32'h200, 32'hDEADBEEF};
        tab[6]  = '{0,1,0,0,S_ACC, 32'hC, 32'h200,32'h12345678,0,
                    0,1,0,0,0, 32'h200, 0};
        tab[7]  = '{0,1,0,0,S_ACC, 32'hC, 32'h200,32'h12345678,0,
                    1,0,1,1,0, 32'hC, 0};
        tab[8]  = '{0,0,0,1,S_ACC, 32'h10,0,0,0, 1,0,1,1,1, 32'h10, 0};
        tab[9]  = '{0,0,0,1,S_BUSY,32'h14,0,0,0, 1,0,0,0,0, 32'h14, 0};
        tab[10] = '{0,0,0,1,S_ACC, 32'h14,0,0,0, 1,0,1,1,1, 32'h14, 0};
        tab[11] = '{1,1,0,0,S_ACC, 32'h18,32'h300,32'h55,0,
                    0,1,0,0,0, 32'h300, 0};
        tab[12] = '{1,1,0,0,S_ACC, 32'h18,32'h300,32'h55,0,
                    1,0,1,1,0, 32'h18, 0};
        tab[13] = '{0,0,0,0,S_ERR, 32'h1C,0,0,0, 1,0,0,0,0, 32'h1C, 0};
        tab[14] = '{0,0,0,0,S_ACC, 32'h1C,0,0,0, 1,0,1,1,0, 32'h1C, 0};

        idle_in();
        iaddr = '0;
        RST = 1;
        #2;
        chk("rst_ramREN", {31'b0, ramREN}, 0);
        chk("rst_ifidW", {31'b0, ifidW}, 0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            dREN = tab[i].ren_; dWEN = tab[i].wen_; halt = tab[i].hlt_;
            brTaken = tab[i].br; ramstate = tab[i].st; iaddr = tab[i].ia;
            daddr = tab[i].da; dstore = tab[i].ds; ramload = tab[i].rl;
            cyc_check($sformatf("vec%0d_model", i));
            chk($sformatf("vec%0d_ctl", i),
                {27'b0, ramREN, ramWEN, ihit, ifidW & idexW & exmemW & memwbW,
                 ifidRST & idexRST & exmemRST},
                {27'b0, tab[i].e_ren, tab[i].e_wen, tab[i].e_ihit,
                 tab[i].e_w, tab[i].e_fl});
            chk($sformatf("vec%0d_addr", i), ramaddr, tab[i].e_addr);
            chk($sformatf("vec%0d_dload", i), dload, tab[i].e_dl);
            tick();
        end

        // ERR_LIMIT consecutive ERROR cycles is fatal
        idle_in(); do_reset();
        ramstate = S_ERR;
        for (int i = 0; i < LIM; i++) begin
            cyc_check("err_run");
            tick();
        end
        ramstate = S_ACC;
        cyc_check("err_fatal_model");
        chk("err_fatal_mem_err", {31'b0, mem_err}, 1);
        chk("err_fatal_halted", {31'b0, halted}, 1);
        chk("err_fatal_ramREN", {31'b0, ramREN}, 0);
        tick();

        // One short of the limit, then ACCESS clears the run
        idle_in(); do_reset();
        for (int k = 0; k < 2; k++) begin
            ramstate = S_ERR;
            for (int i = 0; i < LIM - 1; i++) begin
                cyc_check("err_short");
                tick();
            end
            ramstate = S_ACC;
            cyc_check("err_clear");
            chk("err_clear_ihit", {31'b0, ihit}, 1);
            chk("err_clear_mem_err", {31'b0, mem_err}, 0);
            tick();
        end

        // Halt waits for the pending store, then stops fetching
        idle_in(); do_reset();
        dWEN = 1; halt = 1; daddr = 32'h200; dstore = 32'h12345678;
        ramstate = S_BUSY;
        cyc_check("halt_st_busy");
        chk("halt_st_busy_wen", {31'b0, ramWEN}, 1);
        tick();
        ramstate = S_ACC;
        cyc_check("halt_st_acc");
        chk("halt_st_acc_wen", {31'b0, ramWEN}, 1);
        tick();
        cyc_check("halt_drain");
        chk("halt_drain_ren_wen", {30'b0, ramREN, ramWEN}, 0);
        chk("halt_drain_W", {31'b0, ifidW}, 0);
        tick();
        cyc_check("halt_done");
        chk("halt_done_halted", {31'b0, halted}, 1);
        chk("halt_done_ren", {31'b0, ramREN}, 0);
        tick();

        // Asynchronous reset in the middle of a BUSY store
        idle_in(); do_reset();
        dWEN = 1; daddr = 32'h240; ramstate = S_BUSY;
        cyc_check("arst_busy");
        tick();
        #1;
        RST = 1;
        #1;
        chk("arst_wen", {31'b0, ramWEN}, 0);
        chk("arst_ren_W", {30'b0, ramREN, memwbW}, 0);
        cyc_check("arst_model");
        tick();
        RST = 0;

        // Random traffic against the reference model
        idle_in();
        for (int c = 0; c < 3000; c++) begin
            int op, sr;
            op = $urandom_range(0, 7);
            dREN = (op == 0 || op == 2);
            dWEN = (op == 1 || op == 2);
            halt = ($urandom_range(0, 59) == 0);
            brTaken = ($urandom_range(0, 3) == 0);
            sr = $urandom_range(0, 9);
            ramstate = (sr < 6) ? S_ACC : (sr < 8) ? S_BUSY :
                       (sr < 9) ? S_FREE : S_ERR;
            iaddr = $urandom; daddr = $urandom;
            dstore = $urandom; ramload = $urandom;
            RST = (m_halted && $urandom_range(0, 3) == 0) ||
                  ($urandom_range(0, 299) == 0);
            cyc_check("rand");
            tick();
        end
        RST = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
